// File: rtl/vga_timing_core.sv
// vga_timing_core
// Builds VGA raster timing from one system clock. A clock divider produces a
// one-clk pixel strobe and a 50% duty pixel clock. The horizontal and vertical
// counters advance on the strobe. Sync and display-enable outputs are decoded
// from the next-count values, so they change in the same clk as the counters.
// A linear visible-pixel index and line/frame start pulses are also provided,
// so a downstream buffer can align its prefetch.
//
// Ports:
//   i_clk           system clock (the only clock)
//   i_rst           synchronous reset, active low
//   i_en            run enable; low holds the raster idle
//   o_vga_clk       pixel clock, period CLK_DIV clk cycles
//   o_pix_stb       one-clk pulse per pixel
//   o_h_count       horizontal position 0..H_TOTAL-1
//   o_v_count       vertical position 0..V_TOTAL-1
//   o_h_sync        horizontal sync, active level SYNC_POL
//   o_v_sync        vertical sync, active level SYNC_POL
//   o_h_en          h_count < H_DISP
//   o_v_en          v_count < V_DISP
//   o_p_count       linear index of the current visible pixel
//   o_p_disp_max    constant H_DISP*V_DISP-1
//   o_line_start    pulse when h_count wraps to 0
//   o_frame_start   pulse when (h,v) wraps to (0,0)
module vga_timing_core #(
  parameter int CLK_DIV  = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_vga_clk,
  output logic        o_pix_stb,
  output logic [10:0] o_h_count,
  output logic [10:0] o_v_count,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_h_en,
  output logic        o_v_en,
  output logic [20:0] o_p_count,
  output logic [20:0] o_p_disp_max,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [3:0]  DIV_HALF  = 4'(CLK_DIV / 2);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_DISP_W  = 11'(H_DISP);
  localparam logic [10:0] V_DISP_W  = 11'(V_DISP);
  localparam logic [10:0] HS_ON     = 11'(H_DISP + H_FP);
  localparam logic [10:0] HS_OFF    = 11'(H_DISP + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON     = 11'(V_DISP + V_FP);
  localparam logic [10:0] VS_OFF    = 11'(V_DISP + V_FP + V_SYNC);
  localparam logic [20:0] P_MAX     = 21'(H_DISP * V_DISP - 1);
  localparam logic        SYNC_ACT  = (SYNC_POL != 0);

  // IDLE: held at rest. ARM: divider running, no pixel yet; the first strobe
  // starts the raster at (0,0). RUN: normal raster.
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_div, w_div_next;
  logic [10:0] r_h, w_h_next;
  logic [10:0] r_v, w_v_next;
  logic [20:0] r_p, w_p_next;
  logic        r_vga_clk, r_pix_stb, r_h_sync, r_v_sync;
  logic        r_h_en, r_v_en, r_line_start, r_frame_start;
  logic        w_tick, w_active, w_ls_next, w_fs_next;
  logic        w_h_en_next, w_v_en_next, w_hs_next, w_vs_next, w_vga_next;

  always_comb begin
    // Defaults are the idle values; en low falls straight through to them.
    w_state_next = ST_IDLE;
    w_div_next   = '0;
    w_h_next     = '0;
    w_v_next     = '0;
    w_p_next     = '0;
    w_tick       = 1'b0;
    w_active     = 1'b0;
    w_ls_next    = 1'b0;
    w_fs_next    = 1'b0;
    if (i_en) begin
      case (r_state)
        ST_IDLE: w_state_next = ST_ARM;
        ST_ARM: begin
          w_state_next = ST_ARM;
          w_div_next   = r_div + 4'd1;
          if (w_div_next == DIV_LAST) begin
            w_state_next = ST_RUN;
            w_tick       = 1'b1;
            w_active     = 1'b1;
            w_ls_next    = 1'b1;
            w_fs_next    = 1'b1;
          end
        end
        ST_RUN: begin
          w_state_next = ST_RUN;
          w_active     = 1'b1;
          w_div_next   = (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
          w_h_next     = r_h;
          w_v_next     = r_v;
          w_p_next     = r_p;
          if (w_div_next == DIV_LAST) begin
            w_tick = 1'b1;
            if (r_h == H_LAST) begin
              w_h_next  = '0;
              w_ls_next = 1'b1;
              if (r_v == V_LAST) begin
                w_v_next  = '0;
                w_fs_next = 1'b1;
              end else begin
                w_v_next = r_v + 11'd1;
              end
            end else begin
              w_h_next = r_h + 11'd1;
            end
            // Frame clear wins; otherwise count the pixel just left if visible.
            if (w_fs_next)
              w_p_next = '0;
            else if (r_h_en && r_v_en)
              w_p_next = r_p + 21'd1;
          end
        end
        default: ;
      endcase
    end
    // Decode from next counts so the registered outputs line up with them.
    w_h_en_next = w_active && (w_h_next < H_DISP_W);
    w_v_en_next = w_active && (w_v_next < V_DISP_W);
    w_hs_next   = (w_active && w_h_next >= HS_ON && w_h_next < HS_OFF) ? SYNC_ACT : ~SYNC_ACT;
    w_vs_next   = (w_active && w_v_next >= VS_ON && w_v_next < VS_OFF) ? SYNC_ACT : ~SYNC_ACT;
    w_vga_next  = (w_div_next >= DIV_HALF);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_p           <= '0;
      r_vga_clk     <= 1'b0;
      r_pix_stb     <= 1'b0;
      r_h_sync      <= ~SYNC_ACT;
      r_v_sync      <= ~SYNC_ACT;
      r_h_en        <= 1'b0;
      r_v_en        <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_div         <= w_div_next;
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_p           <= w_p_next;
      r_vga_clk     <= w_vga_next;
      r_pix_stb     <= w_tick;
      r_h_sync      <= w_hs_next;
      r_v_sync      <= w_vs_next;
      r_h_en        <= w_h_en_next;
      r_v_en        <= w_v_en_next;
      r_line_start  <= w_ls_next;
      r_frame_start <= w_fs_next;
    end
  end

  assign o_vga_clk     = r_vga_clk;
  assign o_pix_stb     = r_pix_stb;
  assign o_h_count     = r_h;
  assign o_v_count     = r_v;
  assign o_h_sync      = r_h_sync;
  assign o_v_sync      = r_v_sync;
  assign o_h_en        = r_h_en;
  assign o_v_en        = r_v_en;
  assign o_p_count     = r_p;
  assign o_p_disp_max  = P_MAX;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core
// Directed bench with two instances: default 640x480 timing (line-level and
// early-frame checks) and a tiny raster (full-frame checks).
module tb_vga_timing_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // default instance
  logic        d_rst, d_en;
  logic        d_vga, d_stb, d_hs, d_vs, d_hen, d_ven, d_ls, d_fs;
  logic [10:0] d_h, d_v;
  logic [20:0] d_p, d_pmax;

  // small instance
  logic        s_rst, s_en;
  logic        s_vga, s_stb, s_hs, s_vs, s_hen, s_ven, s_ls, s_fs;
  logic [10:0] s_h, s_v;
  logic [20:0] s_p, s_pmax;

  vga_timing_core u_dflt (
    .i_clk(clk), .i_rst(d_rst), .i_en(d_en),
    .o_vga_clk(d_vga), .o_pix_stb(d_stb), .o_h_count(d_h), .o_v_count(d_v),
    .o_h_sync(d_hs), .o_v_sync(d_vs), .o_h_en(d_hen), .o_v_en(d_ven),
    .o_p_count(d_p), .o_p_disp_max(d_pmax),
    .o_line_start(d_ls), .o_frame_start(d_fs)
  );

  vga_timing_core #(
    .CLK_DIV(2), .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0)
  ) u_small (
    .i_clk(clk), .i_rst(s_rst), .i_en(s_en),
    .o_vga_clk(s_vga), .o_pix_stb(s_stb), .o_h_count(s_h), .o_v_count(s_v),
    .o_h_sync(s_hs), .o_v_sync(s_vs), .o_h_en(s_hen), .o_v_en(s_ven),
    .o_p_count(s_p), .o_p_disp_max(s_pmax),
    .o_line_start(s_ls), .o_frame_start(s_fs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] flags,
                          input logic [10:0] h, input logic [10:0] v, input logic [20:0] p);
    // flags = {vga_clk, pix_stb, h_en, v_en, line_start, frame_start, h_sync, v_sync}
    chk({tag, "_flags"}, 32'(flags), 32'h03);
    chk({tag, "_h"}, 32'(h), 0);
    chk({tag, "_v"}, 32'(v), 0);
    chk({tag, "_p"}, 32'(p), 0);
  endtask

  task automatic wait_d(input int h, input int v, input int budget, input string tag);
    int n = 0;
    while (!(d_stb && d_h == h && d_v == v) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_reached"}, 32'(n < budget), 1);
  endtask

  task automatic wait_s(input int h, input int v, input int budget, input string tag);
    int n = 0;
    while (!(s_stb && s_h == h && s_v == v) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_reached"}, 32'(n < budget), 1);
  endtask

  // clk edges from the current point until the next pix_stb (0 if none in budget)
  task automatic cycles_to_stb_d(output int c);
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (d_stb) begin c = i; break; end
    end
  endtask

  task automatic cycles_to_stb_s(output int c);
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (s_stb) begin c = i; break; end
    end
  endtask

  initial begin
    int c, cyc, stb2, vga_hi, hs_low, hs_first, p639, hen640;
    int vs_low, vs_bad, ven_cnt, hen_cnt, ls_cnt, p_last, p_blank, p_end;

    d_rst = 1'b0; d_en = 1'b1;
    s_rst = 1'b0; s_en = 1'b0;

    // ---------------- default instance ----------------
    repeat (3) tick();
    chk_idle("d_reset", {d_vga, d_stb, d_hen, d_ven, d_ls, d_fs, d_hs, d_vs}, d_h, d_v, d_p);
    chk("d_p_disp_max", 32'(d_pmax), 307199);

    d_rst = 1'b1;
    cycles_to_stb_d(c);
    chk("d_first_stb_cycle", c, 4);
    chk("d_first_fs", 32'(d_fs), 1);
    chk("d_first_ls", 32'(d_ls), 1);
    chk("d_first_hv", {5'd0, d_h, 5'd0, d_v}, 0);
    chk("d_first_en", {d_hen, d_ven}, 2'b11);

    // one full line from the frame start
    cyc = 0; stb2 = 0; vga_hi = 0; hs_low = 0; hs_first = -1; p639 = -1; hen640 = -1;
    do begin
      tick();
      cyc++;
      if (cyc <= 8) vga_hi += int'(d_vga);
      if (d_stb && stb2 == 0) stb2 = cyc;
      if (d_stb && !d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_h);
      end
      if (d_stb && d_h == 639 && d_v == 0) p639 = int'(d_p);
      if (d_stb && d_h == 640 && d_v == 0) hen640 = int'(d_hen);
    end while (!d_ls && cyc < 4000);
    chk("d_stb_period", stb2, 4);
    chk("d_vga_clk_high_of_8", vga_hi, 4);
    chk("d_line_period", cyc, 3200);
    chk("d_hsync_low_pixels", hs_low, 96);
    chk("d_hsync_first_h", hs_first, 656);
    chk("d_p_at_639_0", p639, 639);
    chk("d_hen_at_640", hen640, 0);
    chk("d_line1_hv", {5'd0, d_h, 5'd0, d_v}, 32'h0000_0001);
    chk("d_p_at_0_1", 32'(d_p), 640);
    chk("d_fs_at_line1", 32'(d_fs), 0);
    chk("d_vsync_line1", 32'(d_vs), 1);
    tick();
    chk("d_ls_one_clk", 32'(d_ls), 0);

    // en drop mid-line
    wait_d(100, 1, 1000, "d_at_100_1");
    chk("d_p_at_100_1", 32'(d_p), 740);
    d_en = 1'b0;
    tick();
    chk_idle("d_en_drop", {d_vga, d_stb, d_hen, d_ven, d_ls, d_fs, d_hs, d_vs}, d_h, d_v, d_p);
    d_en = 1'b1;
    cycles_to_stb_d(c);
    chk("d_en_restart_cycle", c, 4);
    chk("d_en_restart_fs", 32'(d_fs), 1);
    chk("d_en_restart_hv", {5'd0, d_h, 5'd0, d_v}, 0);

    // reset mid-line inside h_sync
    wait_d(700, 1, 8000, "d_at_700_1");
    chk("d_hsync_at_700", 32'(d_hs), 0);
    d_rst = 1'b0;
    tick();
    chk_idle("d_rst_mid", {d_vga, d_stb, d_hen, d_ven, d_ls, d_fs, d_hs, d_vs}, d_h, d_v, d_p);
    d_rst = 1'b1;
    cycles_to_stb_d(c);
    chk("d_rst_restart_cycle", c, 4);
    chk("d_rst_restart_fs", 32'(d_fs), 1);
    d_rst = 1'b0;

    // ---------------- small instance ----------------
    s_en = 1'b1;
    repeat (2) tick();
    chk_idle("s_reset", {s_vga, s_stb, s_hen, s_ven, s_ls, s_fs, s_hs, s_vs}, s_h, s_v, s_p);
    chk("s_p_disp_max", 32'(s_pmax), 11);
    s_rst = 1'b1;
    cycles_to_stb_s(c);
    chk("s_first_stb_cycle", c, 2);
    chk("s_first_fs", 32'(s_fs), 1);

    cyc = 0; hs_low = 0; vs_low = 0; vs_bad = 0; ven_cnt = 0; hen_cnt = 0; ls_cnt = 0;
    p_last = -1; p_blank = -1; p_end = -1;
    do begin
      tick();
      cyc++;
      if (s_stb) begin
        if (!s_hs) hs_low++;
        if (!s_vs) begin
          vs_low++;
          if (s_v != 4) vs_bad++;
        end
        if (s_ven) ven_cnt++;
        if (s_hen) hen_cnt++;
        if (s_h == 3 && s_v == 2) p_last = int'(s_p);
        if (s_h == 5 && s_v == 2) p_blank = int'(s_p);
        if (s_h == 7 && s_v == 5) p_end = int'(s_p);
      end
      ls_cnt += int'(s_ls);
    end while (!s_fs && cyc < 200);
    chk("s_frame_period", cyc, 96);
    chk("s_hsync_low_pixels", hs_low, 12);
    chk("s_vsync_low_pixels", vs_low, 8);
    chk("s_vsync_wrong_line", vs_bad, 0);
    chk("s_ven_pixels", ven_cnt, 24);
    chk("s_hen_pixels", hen_cnt, 24);
    chk("s_line_starts", ls_cnt, 6);
    chk("s_p_at_3_2", p_last, 11);
    chk("s_p_at_5_2", p_blank, 12);
    chk("s_p_at_7_5", p_end, 12);
    chk("s_wrap_ls", 32'(s_ls), 1);
    chk("s_wrap_p", 32'(s_p), 0);
    chk("s_wrap_hv", {5'd0, s_h, 5'd0, s_v}, 0);

    // reset mid-frame inside v_sync
    wait_s(6, 4, 200, "s_at_6_4");
    chk("s_vsync_at_6_4", 32'(s_vs), 0);
    s_rst = 1'b0;
    tick();
    chk_idle("s_rst_mid", {s_vga, s_stb, s_hen, s_ven, s_ls, s_fs, s_hs, s_vs}, s_h, s_v, s_p);
    s_rst = 1'b1;
    cycles_to_stb_s(c);
    chk("s_rst_restart_cycle", c, 2);
    chk("s_rst_restart_fs", 32'(s_fs), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_core.md
Name: vga_timing_core

Overview:
- Generates VGA raster timing from a single system clock: pixel strobe, pixel clock, horizontal/vertical counters, sync pulses and display-enable windows.
- Feeds the Wishbone VGA graphic interface directly; that stage fetches VRAM and drives r/g/b.
- Also supplies a linear visible-pixel index, the constant display extent, and frame/line start pulses so the downstream buffer can align its Wishbone prefetch.

Parameters:
- CLK_DIV, 4, system clocks per pixel; 100 MHz clk gives a 25 MHz pixel rate. Legal range 2..16, even only.
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_DISP, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of h_sync/v_sync; 0 means active-low.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-low reset.
- en  in  1  timing run enable; low holds the raster idle.
- vga_clk  out  1  pixel clock; 50% duty, period CLK_DIV clk cycles.
- pix_stb  out  1  one-clk pulse per pixel; counters advance on it.
- h_count  out  11  horizontal position, 0..H_TOTAL-1.
- v_count  out  11  vertical position, 0..V_TOTAL-1.
- h_sync  out  1  horizontal sync.
- v_sync  out  1  vertical sync.
- h_en  out  1  high when h_count < H_DISP.
- v_en  out  1  high when v_count < V_DISP.
- p_count  out  21  linear index of the current visible pixel.
- p_disp_max  out  21  constant H_DISP*V_DISP-1.
- line_start  out  1  one-clk pulse when h_count wraps to 0.
- frame_start  out  1  one-clk pulse when (h,v) wraps to (0,0).

Behaviour:
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
- Reset (rst==0 at a clk edge):
  - div, h_count, v_count and p_count go to 0.
  - vga_clk, pix_stb, line_start and frame_start go to 0.
  - h_en and v_en go to 0.
  - h_sync and v_sync go to the inactive level (~SYNC_POL).
  - Reset mid-line or mid-frame aborts the raster immediately with no completion.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_stb is high exactly when div==CLK_DIV-1.
  - vga_clk is high when div >= CLK_DIV/2.
- en==0: divider and all counters held at 0; all outputs at their reset values. p_disp_max is always valid.
- en rising: the first pix_stb occurs CLK_DIV cycles later. The raster then starts at (0,0) with frame_start.
- Horizontal counter: on pix_stb, h_count increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: v_count increments only on a horizontal wrap. At V_TOTAL-1 it wraps to 0.
- Output alignment: all outputs are registered and change in the same clk as the counters they describe. Decode uses next-count values so there is zero skew versus h_count/v_count.
- h_sync is active for H_DISP+H_FP <= h_count < H_DISP+H_FP+H_SYNC, i.e. 656..751 with defaults.
- v_sync is active for V_DISP+V_FP <= v_count < V_DISP+V_FP+V_SYNC, i.e. 490..491 with defaults.
- p_count:
  - Cleared to 0 on each frame wrap.
  - Otherwise incremented on pix_stb when the pixel being left was visible (h_en && v_en).
  - So p_count equals v*H_DISP+h during visible pixels and holds during blanking.
  - It never exceeds p_disp_max+1, and only reaches that value in the blanking after the last pixel.
- line_start is asserted with the pix_stb that sets h_count to 0.
- frame_start is asserted together with line_start when v_count also goes to 0.
- Simultaneous events:
  - At frame wrap, line_start and frame_start are both 1 in the same cycle.
  - The p_count clear takes priority over the increment.
- en falling mid-frame: takes effect at the next clk edge. Outputs return to idle values and no partial pulse is emitted.

Test Plan:
- Reset: hold rst=0 for 3 clk with en=1, then release.
  - During reset: all counters 0, h_sync=v_sync=1, h_en=0.
  - First pix_stb at cycle 4 after release; frame_start=1 there.
- Line timing, defaults:
  - pix_stb period is 4 clk; vga_clk is high 2 clk and low 2 clk.
  - h_sync is low for exactly 96 pix_stb starting at h_count=656.
  - line_start repeats every 3200 clk.
- Frame timing:
  - v_sync is low for lines 490..491 only.
  - frame_start repeats every 800*525*4 = 1,680,000 clk.
  - v_en is high for lines 0..479.
- Pixel index:
  - At (h=639, v=0), p_count=639; at (0,1), 640.
  - At (639,479), p_count=307199, equal to p_disp_max.
  - p_count holds through blanking and returns to 0 at frame_start.
- Enable and reset mid-frame:
  - Drop en at (h=100, v=200): the next clk shows all outputs idle.
  - Re-raise en: the raster restarts at (0,0) with frame_start.
  - Repeat with rst=0 at (h=700, v=491): same required response.
- Small parameter set: CLK_DIV=2, H_DISP=4, H_FP=1, H_SYNC=2, H_BP=1, V_DISP=3, V_FP=1, V_SYNC=1, V_BP=1.
  - H_TOTAL=8, V_TOTAL=6.
  - p_disp_max=11.
  - Full wrap occurs every 96 clk.
